// File: rtl/divide_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
// divide_seq and divide_step both import this package.
package divide_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width; it holds WIDTH-1 down to 0.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/divide_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; no clock, no handshake.
module divide_step
  import divide_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;

  // The remainder stays below the divisor, so its top bit is normally clear;
  // if it were set, the shifted value would exceed any divisor.
  always_comb begin
    shifted = {rem_i[WIDTH-1:0], dvd_bit_i};
    dvs_ext = {1'b0, divisor_i};
    q_bit_o = rem_i[WIDTH] | (shifted >= dvs_ext);
    rem_o   = q_bit_o ? (shifted - dvs_ext) : shifted;
  end

endmodule

// File: rtl/divide_seq.sv
// Iterative unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
// DIVIDE_SEQ_ZERO_FAST_EN: a zero divisor skips the iterations and goes straight to DONE.
module divide_seq
  import divide_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             deliver;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] shf_next;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

  divide_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (prem_q),
    .dvd_bit_i(shf_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_q)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  assign shf_next = {shf_q[WIDTH-2:0], step_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DIVIDE_SEQ_ZERO_FAST_EN
          state_d = (divisor == '0) ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (deliver) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    shf_d  = shf_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dz_d   = dz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shf_d  = dividend;
          dvs_d  = divisor;
          prem_d = '0;
          cnt_d  = CNT_LOAD;
          dz_d   = (divisor == '0);
`ifdef DIVIDE_SEQ_ZERO_FAST_EN
          if (divisor == '0) begin
            quot_d = '1;
            rem_d  = dividend;
          end
`endif
        end
      end
      CALC: begin
        shf_d  = shf_next;
        prem_d = step_rem;
        if (cnt_q == '0) begin
          quot_d = shf_next;
          rem_d  = step_rem[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      shf_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      shf_q  <= shf_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dz_q   <= dz_d;
    end
  end

endmodule
